// File: rtl/support_io_bridge.sv
// rtl/support_io_bridge.sv - Z80 I/O cycle to per-window slave bridge with WAIT
// insertion, registered read return, ack timeout and unmapped-window handling.
module support_io_bridge #(
  parameter int NDEV     = 16,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic [7:0]           A_i,
  input  logic [7:0]           D_i,
  output logic [7:0]           D_o,
  input  logic                 nrd_i,
  input  logic                 nwr_i,
  input  logic                 niorq_i,
  output logic                 nwait_o,
  output logic [NDEV-1:0]      stb_o,
  output logic                 we_o,
  output logic [7:0]           adr_o,
  output logic [7:0]           dat_o,
  input  logic [8*NDEV-1:0]    dat_i,
  input  logic [NDEV-1:0]      ack_i,
  output logic                 timeout_o,
  output logic [7:0]           err_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [NDEV-1:0] stb_q, stb_d;
  logic            we_q, we_d;
  logic [7:0]      adr_q, adr_d;
  logic [7:0]      dat_q, dat_d;
  logic [7:0]      d_q, d_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                io_rd, io_wr, io_req;
  logic [SEL_BITS-1:0] sel;
  logic                mapped;
  logic [NDEV-1:0]     dec;
  logic                ack_hit;
  logic [7:0]          rd_data;

  assign io_rd  = ~niorq_i & ~nrd_i;
  assign io_wr  = ~niorq_i & ~nwr_i;
  assign io_req = io_rd | io_wr;
  assign sel    = A_i[7 -: SEL_BITS];
  assign mapped = int'(sel) < NDEV;

  // The held one-hot strobe doubles as the latched device select while BUSY.
  assign ack_hit = |(ack_i & stb_q);

  always_comb begin
    dec     = '0;
    rd_data = 8'hff;
    for (int k = 0; k < NDEV; k++) begin
      dec[k] = (sel == SEL_BITS'(k));
      if (stb_q[k]) rd_data = dat_i[8*k +: 8];
    end
  end

  // Reset overrides WAIT so a CPU caught mid-cycle is never left stalled.
  assign nwait_o = ~(nreset_i & io_req & (state_q != DONE));

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    d_d       = d_q;
    timeout_d = 1'b0;
    err_cnt_d = err_cnt_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (io_req) begin
          adr_d = A_i;
          dat_d = D_i;
          we_d  = io_wr;
          if (mapped) begin
            stb_d   = dec;
            cnt_d   = CW'(TIMEOUT);
            state_d = BUSY;
          end else begin
            d_d     = 8'hff;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (ack_hit) begin
          stb_d   = '0;
          we_d    = 1'b0;
          if (!we_q) d_d = rd_data;
          state_d = DONE;
        end else if (cnt_q <= CW'(1)) begin
          stb_d     = '0;
          we_d      = 1'b0;
          d_d       = 8'hff;
          timeout_d = 1'b1;
          if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        stb_d = '0;
        if (!io_req) begin
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= IDLE;
      stb_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= 8'hff;
      dat_q     <= 8'hff;
      d_q       <= 8'hff;
      timeout_q <= 1'b0;
      err_cnt_q <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      d_q       <= d_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign D_o       = d_q;
  assign timeout_o = timeout_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_support_io_bridge.sv
// tb/tb_support_io_bridge.sv - bench for support_io_bridge: transaction model,
// per-cycle compare and directed Z80 I/O cycles.
module tb_support_io_bridge;

  localparam int NDEV     = 8;
  localparam int SEL_BITS = 4;
  localparam int TIMEOUT  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          a = 8'h00, d = 8'h00;
  logic                nrd = 1'b1, nwr = 1'b1, niorq = 1'b1;
  logic [8*NDEV-1:0]   dat_in = {8'h11, 8'h5A, 8'h3C, 8'h44, 8'h22, 8'h33, 8'h77, 8'h00};
  logic [NDEV-1:0]     ack = '0;
  logic [7:0]          d_out, adr, dat_out, err_cnt;
  logic                nwait, we, timeout;
  logic [NDEV-1:0]     stb;

  int checks = 0, errors = 0;
  bit run = 1'b1;

  support_io_bridge #(.NDEV(NDEV), .SEL_BITS(SEL_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .nreset_i(rst_n), .A_i(a), .D_i(d), .D_o(d_out),
    .nrd_i(nrd), .nwr_i(nwr), .niorq_i(niorq), .nwait_o(nwait),
    .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_out),
    .dat_i(dat_in), .ack_i(ack), .timeout_o(timeout), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = no cycle, 1 = waiting on slave, 2 = finished.
  wire req = !niorq && (!nrd || !nwr);
  int         m_phase = 0, m_dev = 0, m_age = 0;
  logic [7:0] e_adr = 8'hff, e_dat = 8'hff, e_d = 8'hff, e_err = 8'h00;
  logic       e_we = 1'b0, e_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; e_adr <= 8'hff; e_dat <= 8'hff; e_d <= 8'hff;
      e_err <= 8'h00; e_we <= 1'b0; e_to <= 1'b0;
    end else begin
      e_to <= 1'b0;
      if (m_phase == 0 && req) begin
        e_adr <= a; e_dat <= d; e_we <= !nwr;
        if (int'(a >> 4) < NDEV) begin
          m_phase <= 1; m_dev <= int'(a >> 4); m_age <= 0;
        end else begin
          m_phase <= 2; e_d <= 8'hff;
        end
      end else if (m_phase == 1) begin
        if (ack[m_dev]) begin
          m_phase <= 2; e_we <= 1'b0;
          if (!e_we) e_d <= dat_in[m_dev*8 +: 8];
        end else if (m_age == TIMEOUT - 1) begin
          m_phase <= 2; e_we <= 1'b0; e_d <= 8'hff; e_to <= 1'b1;
          if (e_err != 8'hff) e_err <= e_err + 8'd1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (m_phase == 2 && !req) begin
        m_phase <= 0; e_we <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("stb", stb, (m_phase == 1) ? (32'd1 << m_dev) : 32'd0);
      chk("nwait", nwait, !(rst_n && req && m_phase != 2));
      chk("we", we, e_we);
      chk("adr", adr, e_adr);
      chk("dat_o", dat_out, e_dat);
      chk("D_o", d_out, e_d);
      chk("timeout", timeout, e_to);
      chk("err_cnt", err_cnt, e_err);
    end
  end

  // Drives one Z80 cycle and holds it until WAIT releases; ack masks are
  // applied for a single cycle at indices c1/c2 (cycle 0 = request cycle).
  task automatic io_cycle(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input int c1, input logic [7:0] m1, input int c2, input logic [7:0] m2,
                          output int lows, output logic [7:0] stb_seen, output logic we_seen);
    a = addr; d = data; niorq = 1'b0;
    if (wr) nwr = 1'b0; else nrd = 1'b0;
    lows = 0; stb_seen = '0; we_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ack = ((c == c1) ? m1 : 8'h00) | ((c == c2) ? m2 : 8'h00);
      #3;
      stb_seen = stb_seen | stb;
      we_seen  = we_seen | we;
      if (nwait) break;
      lows++;
      @(posedge clk); #1;
    end
    ack = '0;
  endtask

  task automatic end_cycle();
    niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
    @(posedge clk); #1;
  endtask

  int         lows;
  logic [7:0] ss;
  logic       ws;

  initial begin
    @(posedge clk); #1;
    chk("reset adr", adr, 8'hff);
    chk("reset D_o", d_out, 8'hff);
    chk("reset stb", stb, 8'h00);
    chk("reset nwait", nwait, 1'b1);
    chk("reset err", err_cnt, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    io_cycle(1'b1, 8'h37, 8'hA5, 2, 8'h08, -1, 8'h00, lows, ss, ws);
    chk("wr lows", lows, 3);
    chk("wr stb", ss, 8'h08);
    chk("wr we", ws, 1'b1);
    chk("wr adr", adr, 8'h37);
    chk("wr dat", dat_out, 8'hA5);
    chk("wr stb off", stb, 8'h00);
    end_cycle();

    io_cycle(1'b0, 8'h52, 8'h00, 4, 8'h20, -1, 8'h00, lows, ss, ws);
    chk("rd lows", lows, 5);
    chk("rd stb", ss, 8'h20);
    chk("rd D_o", d_out, 8'h3C);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rd D_o hold", d_out, 8'h3C);
    end
    end_cycle();
    chk("rd D_o idle", d_out, 8'h3C);

    io_cycle(1'b0, 8'h21, 8'h00, -1, 8'h00, -1, 8'h00, lows, ss, ws);
    chk("to lows", lows, TIMEOUT + 1);
    chk("to stb", ss, 8'h04);
    chk("to pulse", timeout, 1'b1);
    chk("to D_o", d_out, 8'hff);
    chk("to err", err_cnt, 8'h01);
    end_cycle();
    chk("to pulse end", timeout, 1'b0);

    io_cycle(1'b0, 8'h6E, 8'h00, 1, 8'h40, -1, 8'h00, lows, ss, ws);
    chk("rd6 lows", lows, 2);
    chk("rd6 D_o", d_out, 8'h5A);
    end_cycle();

    io_cycle(1'b0, 8'h90, 8'h00, -1, 8'h00, -1, 8'h00, lows, ss, ws);
    chk("unmap lows", lows, 1);
    chk("unmap stb", ss, 8'h00);
    chk("unmap D_o", d_out, 8'hff);
    chk("unmap to", timeout, 1'b0);
    end_cycle();

    io_cycle(1'b0, 8'h1F, 8'h00, 2, 8'h80, TIMEOUT, 8'h02, lows, ss, ws);
    chk("spur lows", lows, TIMEOUT + 1);
    chk("spur stb", ss, 8'h02);
    chk("spur D_o", d_out, 8'h77);
    chk("spur to", timeout, 1'b0);
    chk("spur err", err_cnt, 8'h01);
    end_cycle();

    a = 8'h25; niorq = 1'b0; nrd = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst busy stb", stb, 8'h04);
    rst_n = 1'b0; #1;
    chk("rst stb", stb, 8'h00);
    chk("rst nwait", nwait, 1'b1);
    chk("rst adr", adr, 8'hff);
    chk("rst err", err_cnt, 8'h00);
    niorq = 1'b1; nrd = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    io_cycle(1'b1, 8'h4C, 8'h81, 3, 8'h10, -1, 8'h00, lows, ss, ws);
    chk("post lows", lows, 4);
    chk("post stb", ss, 8'h10);
    chk("post adr", adr, 8'h4C);
    chk("post dat", dat_out, 8'h81);
    end_cycle();

    run = 1'b0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
